hsv_color_filter: RTL
=====================

Name: hsv_color_filter

Overview:
- Streaming stage that sits directly downstream of the RGB-to-HSV converter and consumes its per-pixel HSV and RGB stream, one pixel per clock.
- Classifies each pixel against a programmable hue window (with wrap-around), a minimum saturation and a minimum brightness.
- Emits a binary mask stream and accumulates per-frame statistics: matched-pixel count and bounding box. Statistics are published once per frame, on the frame-end marker.

Parameters:
- IMG_WIDTH, 640, pixels per line; the x counter wraps here.
- IMG_HEIGHT, 480, lines per frame; the y counter wraps here.
- COORD_W, 10, width of the x/y coordinates and bounding-box outputs.
- COUNT_W, 19, width of the matched-pixel counter; saturates at all-ones.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  pixel qualifier
- in_red / in_green / in_blue  in  8 each  RGB of the pixel
- in_hue / in_saturation / in_brightness  in  8 each  HSV of the pixel
- in_visual  in  1  sideband flag, delayed with the data
- in_done  in  1  one-cycle end-of-frame pulse
- cfg_hue_low / cfg_hue_high  in  8 each  hue window bounds, inclusive
- cfg_sat_min / cfg_val_min  in  8 each  inclusive minimum saturation and brightness
- out_valid  out  1  output pixel qualifier
- out_mask  out  8  255 on match, 0 otherwise
- out_red / out_green / out_blue  out  8 each  RGB output (see Optional Feature)
- out_visual  out  1  delayed in_visual
- out_done  out  1  delayed in_done
- stats_valid  out  1  one-cycle pulse when statistics update
- stats_count  out  COUNT_W  matched pixels in the last frame
- stats_empty  out  1  high when the last frame had no matches
- stats_xmin / stats_xmax / stats_ymin / stats_ymax  out  COORD_W each  bounding box of the last frame

Behaviour:
- **Reset.** While reset_n=0 on a clock edge:
  - all outputs and internal registers go to 0, except stats_empty, which goes to 1;
  - the state machine goes to IDLE.
  - A reset mid-frame discards the partial frame and produces no stats_valid.
- **State machine.** Two states, IDLE and FRAME.
  - IDLE: the cfg_* shadow registers load every cycle.
  - IDLE -> FRAME on the first in_valid.
  - FRAME -> IDLE on in_done. in_done seen while in IDLE also ends a (possibly empty) frame.
  - Shadows are frozen in FRAME, so cfg changes take effect at the next frame.
- **Pixel pipeline.** Fixed latency of 2 cycles from in_* to out_*. All sideband signals are delayed identically.
  - Stage 1 registers these compares:
    - hue_ok: if hue_low <= hue_high, then hue_low <= h <= hue_high; otherwise (wrap-around) h >= hue_low OR h <= hue_high;
    - sat_ok: s >= sat_min;
    - val_ok: v >= val_min;
    - the current x and y coordinates.
  - Stage 2 forms match = valid1 AND hue_ok AND sat_ok AND val_ok; out_mask = match ? 255 : 0.
  - When out_valid=0, out_mask=0.
- **Coordinates.**
  - x increments on each in_valid; at IMG_WIDTH-1 it wraps to 0 and y increments.
  - y wraps to 0 after IMG_HEIGHT-1.
  - Both clear on in_done, after the coinciding pixel (if any) has been tagged.
- **Accumulators, updated in stage 2.**
  - On match: count increments, saturating at all-ones.
  - xmin/ymin take the minimum, xmax/ymax the maximum; the first match of a frame loads all four.
- **Frame end.** When done reaches stage 2:
  - the accumulators are copied to stats_*;
  - stats_empty = (count==0), and the bbox outputs are forced to 0 when empty;
  - stats_valid pulses in the same cycle as out_done;
  - the accumulators clear.
  - A pixel coinciding with in_done is included in the closing frame.
- **Back-to-back frames.** A new frame's in_valid may arrive the cycle after in_done. Its pixels accumulate into freshly cleared accumulators.

Optional Feature:
- Macro: HSV_FILTER_OVERLAY_EN.
- Defined: out_red/green/blue equal the delayed RGB when the pixel matches, and 0 otherwise.
- Undefined: out_red/green/blue are the delayed RGB unmodified. The mask is available only on out_mask.

Decomposition:
- Shared package hsv_filter_pkg holds:
  - IDLE/FRAME state encoding;
  - the MASK_ON=255 and MASK_OFF=0 constants;
  - default IMG_WIDTH/IMG_HEIGHT/COORD_W/COUNT_W.
- One sub-module, hsv_window_compare: the combinational hue wrap-around and sat/val compare, instantiated in stage 1.

Test Plan:
- **Plain hue window.** cfg hue 40..60, sat_min 50, val_min 50. Pixels (h,s,v) = (50,100,100), (61,100,100), (50,49,100) -> out_mask 255, 0, 0, exactly 2 cycles after each input.
- **Wrap-around window.** hue_low=240, hue_high=10. Hues 250, 5, 128 -> mask 255, 255, 0. The boundary values 240 and 10 both match.
- **Bounding box.** IMG_WIDTH=8, IMG_HEIGHT=4 frame; matches only at (2,1) and (5,3); in_done coincides with the last pixel -> stats_valid pulse with out_done, count=2, xmin=2, xmax=5, ymin=1, ymax=3, stats_empty=0.
- **Empty frame and config shadowing.** A frame with no matches -> count=0, stats_empty=1, bbox all 0. Changing cfg_hue_low mid-frame has no effect until after in_done.
- **Reset mid-frame.** reset_n=0 for one cycle after 10 matching pixels -> no stats_valid, all outputs 0, stats_empty=1. The next full frame reports only its own matches.
- **Overlay feature.** With HSV_FILTER_OVERLAY_EN, a non-matching pixel RGB (200,10,10) -> out RGB (0,0,0). Without the macro -> out RGB (200,10,10).

Source files
------------

// File: rtl/hsv_filter_pkg.sv
// Shared types and constants for the HSV colour filter: FSM encoding, mask levels and
// default geometry/counter widths.
package hsv_filter_pkg;

    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;
    localparam int unsigned DEF_COORD_W    = 10;
    localparam int unsigned DEF_COUNT_W    = 19;

    localparam logic [7:0] MASK_ON  = 8'd255;
    localparam logic [7:0] MASK_OFF = 8'd0;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StFrame = 1'b1
    } state_e;

endpackage

// File: rtl/hsv_color_filter_if.sv
// Pixel/config/statistics bundle between the RGB-to-HSV converter side and the filter.
// The slave modport is the filter's view; master is the producer/consumer view.
interface hsv_color_filter_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned COUNT_W = 19
);
    logic               in_valid;
    logic [7:0]         in_red;
    logic [7:0]         in_green;
    logic [7:0]         in_blue;
    logic [7:0]         in_hue;
    logic [7:0]         in_saturation;
    logic [7:0]         in_brightness;
    logic               in_visual;
    logic               in_done;
    logic [7:0]         cfg_hue_low;
    logic [7:0]         cfg_hue_high;
    logic [7:0]         cfg_sat_min;
    logic [7:0]         cfg_val_min;
    logic               out_valid;
    logic [7:0]         out_mask;
    logic [7:0]         out_red;
    logic [7:0]         out_green;
    logic [7:0]         out_blue;
    logic               out_visual;
    logic               out_done;
    logic               stats_valid;
    logic [COUNT_W-1:0] stats_count;
    logic               stats_empty;
    logic [COORD_W-1:0] stats_xmin;
    logic [COORD_W-1:0] stats_xmax;
    logic [COORD_W-1:0] stats_ymin;
    logic [COORD_W-1:0] stats_ymax;

    modport master (
        output in_valid, in_red, in_green, in_blue, in_hue, in_saturation, in_brightness,
        output in_visual, in_done, cfg_hue_low, cfg_hue_high, cfg_sat_min, cfg_val_min,
        input  out_valid, out_mask, out_red, out_green, out_blue, out_visual, out_done,
        input  stats_valid, stats_count, stats_empty, stats_xmin, stats_xmax, stats_ymin,
        input  stats_ymax
    );

    modport slave (
        input  in_valid, in_red, in_green, in_blue, in_hue, in_saturation, in_brightness,
        input  in_visual, in_done, cfg_hue_low, cfg_hue_high, cfg_sat_min, cfg_val_min,
        output out_valid, out_mask, out_red, out_green, out_blue, out_visual, out_done,
        output stats_valid, stats_count, stats_empty, stats_xmin, stats_xmax, stats_ymin,
        output stats_ymax
    );

endinterface

// File: rtl/hsv_window_compare.sv
// Combinational HSV window test: inclusive hue window that may wrap past 255, plus
// inclusive minimum saturation and brightness.
module hsv_window_compare (
    input  logic [7:0] hue_i,
    input  logic [7:0] sat_i,
    input  logic [7:0] val_i,
    input  logic [7:0] hue_low_i,
    input  logic [7:0] hue_high_i,
    input  logic [7:0] sat_min_i,
    input  logic [7:0] val_min_i,
    output logic       hue_ok_o,
    output logic       sat_ok_o,
    output logic       val_ok_o
);

    always_comb begin
        if (hue_low_i <= hue_high_i) begin
            hue_ok_o = (hue_i >= hue_low_i) && (hue_i <= hue_high_i);
        end else begin
            // low > high: window wraps through 255/0
            hue_ok_o = (hue_i >= hue_low_i) || (hue_i <= hue_high_i);
        end
        sat_ok_o = (sat_i >= sat_min_i);
        val_ok_o = (val_i >= val_min_i);
    end

endmodule

// File: rtl/hsv_color_filter.sv
// HSV colour filter: 2-stage mask pipeline with per-frame match count and bounding box.
// Optional HSV_FILTER_OVERLAY_EN blanks the RGB output of non-matching pixels.
module hsv_color_filter
    import hsv_filter_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned COORD_W    = DEF_COORD_W,
    parameter int unsigned COUNT_W    = DEF_COUNT_W
) (
    input logic               clock,
    input logic               reset_n,
    hsv_color_filter_if.slave bus
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

    state_e             state_q;
    logic [7:0]         hue_low_q, hue_high_q, sat_min_q, val_min_q;
    logic [7:0]         hue_low_e, hue_high_e, sat_min_e, val_min_e;
    logic [COORD_W-1:0] x_q, y_q;

    // In IDLE the live config applies, so a frame's first pixel sees the value being latched.
    assign hue_low_e  = (state_q == StIdle) ? bus.cfg_hue_low  : hue_low_q;
    assign hue_high_e = (state_q == StIdle) ? bus.cfg_hue_high : hue_high_q;
    assign sat_min_e  = (state_q == StIdle) ? bus.cfg_sat_min  : sat_min_q;
    assign val_min_e  = (state_q == StIdle) ? bus.cfg_val_min  : val_min_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            hue_low_q  <= '0;
            hue_high_q <= '0;
            sat_min_q  <= '0;
            val_min_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            if (state_q == StIdle) begin
                hue_low_q  <= bus.cfg_hue_low;
                hue_high_q <= bus.cfg_hue_high;
                sat_min_q  <= bus.cfg_sat_min;
                val_min_q  <= bus.cfg_val_min;
            end
            unique case (state_q)
                StIdle:  if (bus.in_valid && !bus.in_done) state_q <= StFrame;
                StFrame: if (bus.in_done) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (bus.in_done) begin
                x_q <= '0;
                y_q <= '0;
            end else if (bus.in_valid) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    logic hue_ok, sat_ok, val_ok;

    hsv_window_compare u_compare (
        .hue_i      (bus.in_hue),
        .sat_i      (bus.in_saturation),
        .val_i      (bus.in_brightness),
        .hue_low_i  (hue_low_e),
        .hue_high_i (hue_high_e),
        .sat_min_i  (sat_min_e),
        .val_min_i  (val_min_e),
        .hue_ok_o   (hue_ok),
        .sat_ok_o   (sat_ok),
        .val_ok_o   (val_ok)
    );

    logic               v1_q, hue_ok1_q, sat_ok1_q, val_ok1_q, vis1_q, done1_q;
    logic [7:0]         r1_q, g1_q, b1_q;
    logic [COORD_W-1:0] x1_q, y1_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            {v1_q, hue_ok1_q, sat_ok1_q, val_ok1_q, vis1_q, done1_q} <= '0;
            {r1_q, g1_q, b1_q} <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else begin
            v1_q      <= bus.in_valid;
            hue_ok1_q <= hue_ok;
            sat_ok1_q <= sat_ok;
            val_ok1_q <= val_ok;
            vis1_q    <= bus.in_visual;
            done1_q   <= bus.in_done;
            r1_q      <= bus.in_red;
            g1_q      <= bus.in_green;
            b1_q      <= bus.in_blue;
            x1_q      <= x_q;
            y1_q      <= y_q;
        end
    end

    logic               match;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [COORD_W-1:0] xmin_d, xmax_d, ymin_d, ymax_d;

    assign match = v1_q && hue_ok1_q && sat_ok1_q && val_ok1_q;

    // Accumulator values including the stage-2 pixel, so a pixel on in_done is counted.
    always_comb begin
        cnt_d  = cnt_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        if (match) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) begin
                xmin_d = x1_q;
                xmax_d = x1_q;
                ymin_d = y1_q;
                ymax_d = y1_q;
            end else begin
                if (x1_q < xmin_q) xmin_d = x1_q;
                if (x1_q > xmax_q) xmax_d = x1_q;
                if (y1_q < ymin_q) ymin_d = y1_q;
                if (y1_q > ymax_q) ymax_d = y1_q;
            end
        end
    end

    logic               out_valid_q, out_visual_q, out_done_q, stats_valid_q, stats_empty_q;
    logic [7:0]         out_mask_q, out_r_q, out_g_q, out_b_q;
    logic [COUNT_W-1:0] stats_count_q;
    logic [COORD_W-1:0] stats_xmin_q, stats_xmax_q, stats_ymin_q, stats_ymax_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            {out_valid_q, out_visual_q, out_done_q, stats_valid_q} <= '0;
            {out_mask_q, out_r_q, out_g_q, out_b_q} <= '0;
            stats_empty_q <= 1'b1;
            stats_count_q <= '0;
            {stats_xmin_q, stats_xmax_q, stats_ymin_q, stats_ymax_q} <= '0;
            cnt_q <= '0;
            {xmin_q, xmax_q, ymin_q, ymax_q} <= '0;
        end else begin
            out_valid_q   <= v1_q;
            out_mask_q    <= match ? MASK_ON : MASK_OFF;
`ifdef HSV_FILTER_OVERLAY_EN
            out_r_q       <= match ? r1_q : 8'd0;
            out_g_q       <= match ? g1_q : 8'd0;
            out_b_q       <= match ? b1_q : 8'd0;
`else
            out_r_q       <= r1_q;
            out_g_q       <= g1_q;
            out_b_q       <= b1_q;
`endif
            out_visual_q  <= vis1_q;
            out_done_q    <= done1_q;
            stats_valid_q <= done1_q;
            if (done1_q) begin
                stats_count_q <= cnt_d;
                stats_empty_q <= (cnt_d == '0);
                stats_xmin_q  <= (cnt_d == '0) ? '0 : xmin_d;
                stats_xmax_q  <= (cnt_d == '0) ? '0 : xmax_d;
                stats_ymin_q  <= (cnt_d == '0) ? '0 : ymin_d;
                stats_ymax_q  <= (cnt_d == '0) ? '0 : ymax_d;
                cnt_q <= '0;
                {xmin_q, xmax_q, ymin_q, ymax_q} <= '0;
            end else begin
                cnt_q  <= cnt_d;
                xmin_q <= xmin_d;
                xmax_q <= xmax_d;
                ymin_q <= ymin_d;
                ymax_q <= ymax_d;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_mask    = out_mask_q;
    assign bus.out_red     = out_r_q;
    assign bus.out_green   = out_g_q;
    assign bus.out_blue    = out_b_q;
    assign bus.out_visual  = out_visual_q;
    assign bus.out_done    = out_done_q;
    assign bus.stats_valid = stats_valid_q;
    assign bus.stats_count = stats_count_q;
    assign bus.stats_empty = stats_empty_q;
    assign bus.stats_xmin  = stats_xmin_q;
    assign bus.stats_xmax  = stats_xmax_q;
    assign bus.stats_ymin  = stats_ymin_q;
    assign bus.stats_ymax  = stats_ymax_q;

endmodule
